btn_debounce_mc: RTL and testbench

BTN_DEBOUNCE_MC -- requirements
Module: btn_debounce_mc

---
 rtl/btn_debounce_mc_if.sv | 30 +++
 rtl/btn_debounce_mc.sv | 127 ++++++++++++
 tb/tb_btn_debounce_mc.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_mc_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_mc_if
// Bundle of the button debouncer's per-channel signals.
//   btn_i  : raw asynchronous button levels (bit n = channel n)
//   btn_o  : debounced stable level per channel
//   rise_o : one-cycle pulse on an accepted 0->1 change
//   fall_o : one-cycle pulse on an accepted 1->0 change
//   hold_o : one-cycle long-press pulse
// master drives the raw buttons and observes the results; slave is the
// debouncer itself.
// -----------------------------------------------------------------------------
interface btn_debounce_mc_if #(
    parameter int NumBtns = 4
) ();
    logic [NumBtns-1:0] btn_i;
    logic [NumBtns-1:0] btn_o;
    logic [NumBtns-1:0] rise_o;
    logic [NumBtns-1:0] fall_o;
    logic [NumBtns-1:0] hold_o;

    modport master (
        output btn_i,
        input  btn_o, rise_o, fall_o, hold_o
    );

    modport slave (
        input  btn_i,
        output btn_o, rise_o, fall_o, hold_o
    );
endinterface

// File: rtl/btn_debounce_mc.sv
// -----------------------------------------------------------------------------
// btn_debounce_mc
// Multi-channel button debouncer with edge and long-press pulses.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset, clears every flop
//   bus    : btn_debounce_mc_if.slave (btn_i in; btn_o/rise_o/fall_o/hold_o out)
// Each channel is an independent btn_debounce_lane instance: synchroniser,
// debounce counter, edge pulses and an optional long-press counter.
// -----------------------------------------------------------------------------
module btn_debounce_lane #(
    parameter int ClkCount   = 500,
    parameter int HoldCount  = 1000000,
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);
    localparam int CntW = $clog2(ClkCount + 1);
    // A change is accepted on the ClkCount-th consecutive differing sample,
    // i.e. when the counter already holds ClkCount-1 differing samples.
    localparam logic [CntW-1:0] CntLast = CntW'(ClkCount - 1);

    logic [SyncStages-1:0] sync_q;
    logic [CntW-1:0]       cnt_q;
    logic                  sync;
    logic                  accept;

    assign sync   = sync_q[SyncStages-1];
    assign accept = (sync != level) && (cnt_q >= CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw};
            // Any sample agreeing with the stable level restarts the count,
            // which is what rejects glitches shorter than ClkCount samples.
            if (sync == level || accept) cnt_q <= '0;
            else                         cnt_q <= cnt_q + CntW'(1);
            if (accept) level <= sync;
            rise <= accept &  sync;
            fall <= accept & ~sync;
        end
    end

    if (HoldCount > 0) begin : g_hold
        localparam int HoldW = $clog2(HoldCount + 1);
        localparam logic [HoldW-1:0] HoldMax  = HoldW'(HoldCount);
        localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCount - 1);

        logic [HoldW-1:0] hcnt_q;

        // Counter saturates at HoldMax, so HoldLast is passed only once per
        // press and the pulse cannot repeat until the level drops.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hcnt_q <= '0;
                hold   <= 1'b0;
            end else if (!level) begin
                hcnt_q <= '0;
                hold   <= 1'b0;
            end else begin
                hold <= (hcnt_q == HoldLast);
                if (hcnt_q != HoldMax) hcnt_q <= hcnt_q + HoldW'(1);
            end
        end
    end else begin : g_no_hold
        assign hold = 1'b0;
    end
endmodule

module btn_debounce_mc #(
    parameter int NumBtns    = 4,
    parameter int ClkCount   = 500,
    parameter int HoldCount  = 1000000,
    parameter int SyncStages = 2
) (
    input logic         clk_i,
    input logic         rst_ni,
    btn_debounce_mc_if.slave bus
);
    if (ClkCount < 1) begin : g_bad_clk_count
        $error("btn_debounce_mc: ClkCount must be >= 1");
    end
    if (SyncStages < 2) begin : g_bad_sync_stages
        $error("btn_debounce_mc: SyncStages must be >= 2");
    end
    if (NumBtns < 1) begin : g_bad_num_btns
        $error("btn_debounce_mc: NumBtns must be >= 1");
    end

    logic [NumBtns-1:0] level;
    logic [NumBtns-1:0] rise;
    logic [NumBtns-1:0] fall;
    logic [NumBtns-1:0] hold;

    for (genvar g = 0; g < NumBtns; g++) begin : g_lane
        btn_debounce_lane #(
            .ClkCount  (ClkCount),
            .HoldCount (HoldCount),
            .SyncStages(SyncStages)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .raw   (bus.btn_i[g]),
            .level (level[g]),
            .rise  (rise[g]),
            .fall  (fall[g]),
            .hold  (hold[g])
        );
    end

    assign bus.btn_o  = level;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;
    assign bus.hold_o = hold;
endmodule

// File: tb/tb_btn_debounce_mc.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_mc
// Scoreboard bench for btn_debounce_mc (4 channels, ClkCount 4, HoldCount 10,
// SyncStages 2). A reference model pushes the expected outputs for every
// clock edge; a monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_btn_debounce_mc;
    localparam int NB = 4;
    localparam int CC = 4;
    localparam int HC = 10;
    localparam int SS = 2;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic [NB-1:0] hold;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t          expq[$];
    logic [NB-1:0] rawq[$];
    logic [NB-1:0] m_lvl;
    int            m_run[NB];
    int            m_since[NB];

    btn_debounce_mc_if #(.NumBtns(NB)) bus ();

    btn_debounce_mc #(
        .NumBtns   (NB),
        .ClkCount  (CC),
        .HoldCount (HC),
        .SyncStages(SS)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]   = 0;
            m_since[c] = 0;
        end
        rawq.delete();
        for (int i = 0; i < SS; i++) rawq.push_back('0);
        expq.delete();
    endtask

    // Reference model: a raw level reaches the decision logic SS edges after
    // it is sampled; CC consecutive differing samples flip the stable level;
    // a long press fires HC edges after the rise.
    initial begin
        logic [NB-1:0] seen;
        exp_t          e;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                seen = rawq.pop_front();
                rawq.push_back(bus.btn_i);
                e = '0;
                for (int c = 0; c < NB; c++) begin
                    if (m_lvl[c]) begin
                        m_since[c]++;
                        if (m_since[c] == HC) e.hold[c] = 1'b1;
                    end else begin
                        m_since[c] = 0;
                    end
                    if (seen[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == CC) begin
                            m_lvl[c] = seen[c];
                            m_run[c] = 0;
                            if (seen[c]) begin
                                e.rise[c]  = 1'b1;
                                m_since[c] = 0;
                            end else begin
                                e.fall[c] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                e.lvl = m_lvl;
                expq.push_back(e);
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_btn_o",  bus.btn_o,  '0);
                chk("reset_rise_o", bus.rise_o, '0);
                chk("reset_fall_o", bus.fall_o, '0);
                chk("reset_hold_o", bus.hold_o, '0);
            end else if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("btn_o",  bus.btn_o,  e.lvl);
                chk("rise_o", bus.rise_o, e.rise);
                chk("fall_o", bus.fall_o, e.fall);
                chk("hold_o", bus.hold_o, e.hold);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Reset asserted between edges must clear every output at once.
    task automatic async_reset(input int low_cycles);
        rst_n = 1'b0;
        #1;
        chk("async_btn_o",  bus.btn_o,  '0);
        chk("async_rise_o", bus.rise_o, '0);
        chk("async_fall_o", bus.fall_o, '0);
        chk("async_hold_o", bus.hold_o, '0);
        tick(low_cycles);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.btn_i = '0;
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Clean press on channel 0
        bus.btn_i = 4'b0001;
        tick(20);
        // Three-cycle glitch on channel 1 is rejected
        bus.btn_i[1] = 1'b1;
        tick(3);
        bus.btn_i[1] = 1'b0;
        tick(15);
        // Long press then release on channel 2
        bus.btn_i[2] = 1'b1;
        tick(30);
        bus.btn_i[2] = 1'b0;
        tick(20);
        // All channels step together
        bus.btn_i = '0;
        tick(20);
        bus.btn_i = 4'b1111;
        tick(20);
        bus.btn_i = '0;
        tick(20);
        // Reset mid-count on channel 3 while channel 0 is stable high
        bus.btn_i = 4'b0001;
        tick(20);
        bus.btn_i[3] = 1'b1;
        tick(5);
        async_reset(2);
        tick(25);

        // Random bouncing buttons with occasional resets
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 99) < 4) bus.btn_i[c] = ~bus.btn_i[c];
            if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 3));
            else tick(1);
        end

        bus.btn_i = '0;
        tick(30);
        checks++;
        if (expq.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want at most 1", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
